riscv_ex_cplq: RTL and testbench
================================

RISCV_EX_CPLQ -- requirements
Module: riscv_ex_cplq

Interface
REQ-001 The parameter list SHALL be: XLEN, 32, result/PC width.
REQ-002 The parameter list SHALL include: NUM_UNITS, 4, number of execution units (ALU, LSU, MUL, DIV, ...); range 2..8.
REQ-003 The parameter list SHALL include: DEPTH, 4, completion-queue entries; power of 2, range 2..16.
REQ-004 The ports SHALL be: clk_i  in  1  clock.
REQ-005 The ports SHALL include: rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 The ports SHALL include: flush_i  in  1  pipeline flush.
REQ-007 The ports SHALL include: mem_stall_i  in  1  downstream (MEM) cannot accept.
REQ-008 The ports SHALL include: issue_valid_i  in  1  ID issues an instruction.
REQ-009 The ports SHALL include: issue_unit_i  in  $clog2(NUM_UNITS)  target unit.
REQ-010 The ports SHALL include: issue_pc_i  in  XLEN  instruction PC.
REQ-011 The ports SHALL include: issue_ready_o  out  1  queue can accept an issue.
REQ-012 The ports SHALL include: ex_stall_o  out  1  issue_valid_i & ~issue_ready_o.
REQ-013 The ports SHALL include: unit_valid_i  in  NUM_UNITS  per-unit result strobe.
REQ-014 The ports SHALL include: unit_r_i  in  NUM_UNITS x XLEN  per-unit result.
REQ-015 The ports SHALL include: unit_exc_i  in  NUM_UNITS  per-unit exception flag.
REQ-016 The ports SHALL include: unit_ready_o  out  NUM_UNITS  unit has an outstanding entry.
REQ-017 The ports SHALL include: ex_valid_o  out  1  head entry is complete.
REQ-018 The ports SHALL include: ex_r_o  out  XLEN  head result.
REQ-019 The ports SHALL include: ex_pc_o  out  XLEN  head PC.
REQ-020 The ports SHALL include: ex_unit_o  out  $clog2(NUM_UNITS)  head unit.
REQ-021 The ports SHALL include: ex_exc_o  out  1  head exception flag.

Function
REQ-022 The block SHALL reorder variable-latency unit results into issue order using a circular FIFO of DEPTH entries {unit, pc, done, exc, r}.
REQ-023 Issue SHALL occur when issue_valid_i & issue_ready_o, and SHALL write the tail entry with done=0 and advance wr_ptr modulo DEPTH.
REQ-024 issue_ready_o SHALL be (count < DEPTH); a same-cycle retire SHALL NOT free a slot for issue in that cycle.
REQ-025 unit_ready_o[u] SHALL be 1 iff an entry present at the start of the cycle has unit==u and done==0.
REQ-026 A result with unit_valid_i[u] & unit_ready_o[u] SHALL set done, write r and exc into the oldest such entry, and become visible on the outputs the next cycle.
REQ-027 A unit_valid_i[u] with unit_ready_o[u]=0 SHALL be dropped with no state change.
REQ-028 Multiple units completing in the same cycle SHALL all be accepted.
REQ-029 A result SHALL never match an entry issued in the same cycle.
REQ-030 ex_valid_o SHALL be (count!=0) & head.done, driven combinationally from registered storage; ex_r_o, ex_pc_o, ex_unit_o and ex_exc_o SHALL reflect the head entry.
REQ-031 Retire SHALL occur when ex_valid_o & ~mem_stall_i, and SHALL advance rd_ptr modulo DEPTH.
REQ-032 When issue and retire occur in the same cycle, count SHALL be unchanged.
REQ-033 Minimum latency SHALL be: issue in cycle N, unit result in N+1, ex_valid_o in N+2.
REQ-034 A head entry with exc=1 SHALL retire normally; the consumer decides on flush.
REQ-035 flush_i SHALL have priority over issue, completion and retire in the same cycle.
REQ-036 flush_i SHALL zero count, rd_ptr and wr_ptr at the next edge, and ex_valid_o SHALL be 0 in the following cycle.
REQ-037 Units are flushed by the same flush_i, so no stale result shall arrive after a flush.

Reset
REQ-038 On rst_ni low, count, rd_ptr, wr_ptr and all done bits SHALL be 0 immediately.
REQ-039 After reset, ex_valid_o=0, issue_ready_o=1 and unit_ready_o=0.
REQ-040 The payload fields unit, pc, r and exc SHALL NOT be reset.
REQ-041 Reset asserted mid-operation SHALL discard all entries.

Structure
REQ-042 The cplq_entry_t typedef SHALL be placed in a shared riscv_ex_pkg.
REQ-043 The NUM_UNITS/DEPTH legality checks SHALL be elaboration-time assertions.
REQ-044 The oldest-pending-entry-per-unit priority finder SHALL be a single sub-module, riscv_ex_cplq_match, instantiated NUM_UNITS times.

Verification
REQ-045 The bench SHALL cover: issue ALU pc=0x200, ALU result 0x5 next cycle -> ex_valid_o=1, ex_r_o=0x5, ex_pc_o=0x200 two cycles after issue.
REQ-046 The bench SHALL cover: issue DIV pc=0x200 then ALU pc=0x204, ALU completes first -> ex_valid_o stays 0 until DIV completes; then 0x200 retires before 0x204.
REQ-047 The bench SHALL cover: DEPTH=4, four issues with no completions -> issue_ready_o=0; a fifth issue_valid_i gives ex_stall_o=1; one retire re-asserts issue_ready_o the next cycle.
REQ-048 The bench SHALL cover: mem_stall_i=1 with a completed head -> outputs hold stable, and a simultaneous issue and retire keep count constant.
REQ-049 The bench SHALL cover: flush_i with 3 entries in flight plus a same-cycle issue -> count=0 and unit_ready_o=0 the next cycle; a later unit_valid_i is dropped.
REQ-050 The bench SHALL cover: pointer wrap over 2*DEPTH+1 mixed-unit instructions -> retire order equals issue order, no loss or duplication.

Source files
------------

// File: rtl/riscv_ex_pkg.sv
// Shared execute-stage types: the completion-queue entry layout.
// Fields are sized for the widest supported configuration; narrower instances use the low bits.
package riscv_ex_pkg;

   localparam int unsigned CPLQ_XLEN_MAX   = 64;
   localparam int unsigned CPLQ_UNIT_W_MAX = 3;

   typedef struct packed {
      logic [CPLQ_UNIT_W_MAX-1:0] unit;
      logic [CPLQ_XLEN_MAX-1:0]   pc;
      logic                       done;
      logic                       exc;
      logic [CPLQ_XLEN_MAX-1:0]   r;
   } cplq_entry_t;

endpackage

// File: rtl/riscv_ex_cplq_match.sv
// Finds the oldest pending entry (present, not done) belonging to one execution unit.
module riscv_ex_cplq_match #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned UNIT_W  = 2,
   parameter int unsigned UNIT_ID = 0
) (
   input  logic [DEPTH-1:0]             pend_i,
   input  logic [DEPTH-1:0][UNIT_W-1:0] unit_i,
   input  logic [$clog2(DEPTH)-1:0]     rd_ptr_i,
   output logic                         hit_o,
   output logic [$clog2(DEPTH)-1:0]     idx_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [PW-1:0] idx;

   // Scan from youngest to oldest so the last hit written is the oldest one.
   always_comb begin
      hit_o = 1'b0;
      idx_o = '0;
      idx   = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         idx = rd_ptr_i + PW'(k);
         if (pend_i[idx] && (unit_i[idx] == UNIT_W'(UNIT_ID))) begin
            hit_o = 1'b1;
            idx_o = idx;
         end
      end
   end

endmodule

// File: rtl/riscv_ex_cplq.sv
// Execute-stage completion queue: reorders variable-latency unit results back into issue order.
module riscv_ex_cplq
   import riscv_ex_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned NUM_UNITS = 4,
   parameter int unsigned DEPTH     = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                flush_i,
   input  logic                                mem_stall_i,
   input  logic                                issue_valid_i,
   input  logic [$clog2(NUM_UNITS)-1:0]        issue_unit_i,
   input  logic [XLEN-1:0]                     issue_pc_i,
   output logic                                issue_ready_o,
   output logic                                ex_stall_o,
   input  logic [NUM_UNITS-1:0]                unit_valid_i,
   input  logic [NUM_UNITS-1:0][XLEN-1:0]      unit_r_i,
   input  logic [NUM_UNITS-1:0]                unit_exc_i,
   output logic [NUM_UNITS-1:0]                unit_ready_o,
   output logic                                ex_valid_o,
   output logic [XLEN-1:0]                     ex_r_o,
   output logic [XLEN-1:0]                     ex_pc_o,
   output logic [$clog2(NUM_UNITS)-1:0]        ex_unit_o,
   output logic                                ex_exc_o
);

   localparam int unsigned UW = $clog2(NUM_UNITS);
   localparam int unsigned PW = $clog2(DEPTH);

   if (NUM_UNITS < 2 || NUM_UNITS > 8) begin : g_bad_num_units
      $error("riscv_ex_cplq: NUM_UNITS must be in 2..8");
   end
   if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("riscv_ex_cplq: DEPTH must be a power of 2 in 2..16");
   end
   if (XLEN < 1 || XLEN > CPLQ_XLEN_MAX) begin : g_bad_xlen
      $error("riscv_ex_cplq: XLEN exceeds cplq_entry_t field width");
   end

   logic [PW:0]                  count_q;
   logic [PW-1:0]                rd_ptr_q;
   logic [PW-1:0]                wr_ptr_q;
   logic [DEPTH-1:0]             done_q;
   logic [DEPTH-1:0]             exc_q;
   logic [DEPTH-1:0][UW-1:0]     unit_q;
   logic [XLEN-1:0]              pc_q [DEPTH];
   logic [XLEN-1:0]              r_q  [DEPTH];

   logic [DEPTH-1:0]             present;
   logic [DEPTH-1:0]             pend;
   logic [PW-1:0]                off;
   logic [NUM_UNITS-1:0]         hit;
   logic [NUM_UNITS-1:0][PW-1:0] hit_idx;
   logic [NUM_UNITS-1:0]         accept;
   logic                         issue_fire;
   logic                         retire_fire;
   cplq_entry_t                  head;
   logic                         unused_head;

   // An entry is live when its distance from the head is below the occupancy.
   always_comb begin
      present = '0;
      off     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off        = PW'(i) - rd_ptr_q;
         present[i] = ({1'b0, off} < count_q);
      end
   end

   assign pend = present & ~done_q;

   for (genvar u = 0; u < NUM_UNITS; u++) begin : g_match
      riscv_ex_cplq_match #(
         .DEPTH   (DEPTH),
         .UNIT_W  (UW),
         .UNIT_ID (u)
      ) u_match (
         .pend_i   (pend),
         .unit_i   (unit_q),
         .rd_ptr_i (rd_ptr_q),
         .hit_o    (hit[u]),
         .idx_o    (hit_idx[u])
      );
   end

   always_comb begin
      head      = '0;
      head.unit = CPLQ_UNIT_W_MAX'(unit_q[rd_ptr_q]);
      head.pc   = CPLQ_XLEN_MAX'(pc_q[rd_ptr_q]);
      head.done = done_q[rd_ptr_q];
      head.exc  = exc_q[rd_ptr_q];
      head.r    = CPLQ_XLEN_MAX'(r_q[rd_ptr_q]);
   end

   assign unused_head   = ^{head.unit, head.pc, head.r};

   assign issue_ready_o = (count_q < (PW+1)'(DEPTH));
   assign ex_stall_o    = issue_valid_i & ~issue_ready_o;
   assign unit_ready_o  = hit;
   assign accept        = unit_valid_i & hit;

   assign ex_valid_o    = (count_q != '0) & head.done;
   assign ex_r_o        = head.r[XLEN-1:0];
   assign ex_pc_o       = head.pc[XLEN-1:0];
   assign ex_unit_o     = head.unit[UW-1:0];
   assign ex_exc_o      = head.exc;

   assign issue_fire    = issue_valid_i & issue_ready_o;
   assign retire_fire   = ex_valid_o & ~mem_stall_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         done_q   <= '0;
      end else if (flush_i) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         done_q   <= '0;
      end else begin
         // The tail slot is never live, so issue and completion never touch the same bit.
         if (issue_fire) begin
            done_q[wr_ptr_q] <= 1'b0;
            wr_ptr_q         <= wr_ptr_q + 1'b1;
         end
         for (int u = 0; u < NUM_UNITS; u++) begin
            if (accept[u]) begin
               done_q[hit_idx[u]] <= 1'b1;
            end
         end
         if (retire_fire) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_q + (PW+1)'(issue_fire) - (PW+1)'(retire_fire);
      end
   end

   // Payload carries no reset; validity is tracked solely by count and done.
   always_ff @(posedge clk_i) begin
      if (issue_fire && !flush_i) begin
         unit_q[wr_ptr_q] <= issue_unit_i;
         pc_q[wr_ptr_q]   <= issue_pc_i;
      end
      for (int u = 0; u < NUM_UNITS; u++) begin
         if (accept[u] && !flush_i) begin
            r_q[hit_idx[u]]   <= unit_r_i[u];
            exc_q[hit_idx[u]] <= unit_exc_i[u];
         end
      end
   end

endmodule

// File: tb/tb_riscv_ex_cplq.sv
// Directed bench for riscv_ex_cplq with NUM_UNITS=4 (0=ALU,1=LSU,2=MUL,3=DIV) and DEPTH=4.
module tb_riscv_ex_cplq;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             flush_i;
   logic             mem_stall_i;
   logic             issue_valid_i;
   logic [1:0]       issue_unit_i;
   logic [31:0]      issue_pc_i;
   logic             issue_ready_o;
   logic             ex_stall_o;
   logic [3:0]       unit_valid_i;
   logic [3:0][31:0] unit_r_i;
   logic [3:0]       unit_exc_i;
   logic [3:0]       unit_ready_o;
   logic             ex_valid_o;
   logic [31:0]      ex_r_o;
   logic [31:0]      ex_pc_o;
   logic [1:0]       ex_unit_o;
   logic             ex_exc_o;

   int n_tests = 0;
   int n_fail  = 0;

   riscv_ex_cplq #(.XLEN(32), .NUM_UNITS(4), .DEPTH(4)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .flush_i       (flush_i),
      .mem_stall_i   (mem_stall_i),
      .issue_valid_i (issue_valid_i),
      .issue_unit_i  (issue_unit_i),
      .issue_pc_i    (issue_pc_i),
      .issue_ready_o (issue_ready_o),
      .ex_stall_o    (ex_stall_o),
      .unit_valid_i  (unit_valid_i),
      .unit_r_i      (unit_r_i),
      .unit_exc_i    (unit_exc_i),
      .unit_ready_o  (unit_ready_o),
      .ex_valid_o    (ex_valid_o),
      .ex_r_o        (ex_r_o),
      .ex_pc_o       (ex_pc_o),
      .ex_unit_o     (ex_unit_o),
      .ex_exc_o      (ex_exc_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      flush_i       = 1'b0;
      mem_stall_i   = 1'b0;
      issue_valid_i = 1'b0;
      issue_unit_i  = '0;
      issue_pc_i    = '0;
      unit_valid_i  = '0;
      unit_r_i      = '0;
      unit_exc_i    = '0;
   endtask

   task automatic issue(input logic [1:0] u, input logic [31:0] pc);
      issue_valid_i = 1'b1;
      issue_unit_i  = u;
      issue_pc_i    = pc;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      idle();
      repeat (3) step();
      n_tests++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid got=%b want=0", ex_valid_o); end
      n_tests++; if (issue_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready got=%b want=1", issue_ready_o); end
      n_tests++; if (unit_ready_o !== 4'b0000) begin n_fail++; $display("FAIL reset_unit_ready got=%b want=0000", unit_ready_o); end
      rst_ni = 1'b1;
      step();
   endtask

   task automatic test_basic();
      issue(2'd0, 32'h200);
      step();
      issue_valid_i   = 1'b0;
      unit_valid_i    = 4'b0001;
      unit_r_i[0]     = 32'h5;
      n_tests++; if (unit_ready_o !== 4'b0001) begin n_fail++; $display("FAIL basic_unit_ready got=%b want=0001", unit_ready_o); end
      n_tests++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got=%b want=0", ex_valid_o); end
      step();
      unit_valid_i = '0;
      n_tests++; if (ex_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b want=1", ex_valid_o); end
      n_tests++; if (ex_r_o !== 32'h5) begin n_fail++; $display("FAIL basic_r got=%h want=5", ex_r_o); end
      n_tests++; if (ex_pc_o !== 32'h200) begin n_fail++; $display("FAIL basic_pc got=%h want=200", ex_pc_o); end
      n_tests++; if (ex_unit_o !== 2'd0 || ex_exc_o !== 1'b0) begin n_fail++; $display("FAIL basic_unit_exc got=%0d/%b want=0/0", ex_unit_o, ex_exc_o); end
      step();
      n_tests++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_drained got=%b want=0", ex_valid_o); end
   endtask

   task automatic test_reorder();
      issue(2'd3, 32'h200);
      step();
      issue(2'd0, 32'h204);
      step();
      issue_valid_i = 1'b0;
      unit_valid_i  = 4'b0001;
      unit_r_i[0]   = 32'h11;
      step();
      unit_valid_i = '0;
      n_tests++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL reorder_hold1 got=%b want=0", ex_valid_o); end
      step();
      n_tests++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL reorder_hold2 got=%b want=0", ex_valid_o); end
      n_tests++; if (unit_ready_o !== 4'b1000) begin n_fail++; $display("FAIL reorder_unit_ready got=%b want=1000", unit_ready_o); end
      unit_valid_i  = 4'b1000;
      unit_r_i[3]   = 32'h22;
      unit_exc_i[3] = 1'b1;
      step();
      unit_valid_i = '0;
      unit_exc_i   = '0;
      n_tests++; if (ex_valid_o !== 1'b1 || ex_pc_o !== 32'h200 || ex_r_o !== 32'h22) begin n_fail++; $display("FAIL reorder_first got v=%b pc=%h r=%h want 1/200/22", ex_valid_o, ex_pc_o, ex_r_o); end
      n_tests++; if (ex_exc_o !== 1'b1 || ex_unit_o !== 2'd3) begin n_fail++; $display("FAIL reorder_first_exc got exc=%b unit=%0d want 1/3", ex_exc_o, ex_unit_o); end
      step();
      n_tests++; if (ex_valid_o !== 1'b1 || ex_pc_o !== 32'h204 || ex_r_o !== 32'h11) begin n_fail++; $display("FAIL reorder_second got v=%b pc=%h r=%h want 1/204/11", ex_valid_o, ex_pc_o, ex_r_o); end
      n_tests++; if (ex_exc_o !== 1'b0) begin n_fail++; $display("FAIL reorder_second_exc got=%b want=0", ex_exc_o); end
      step();
      n_tests++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL reorder_drained got=%b want=0", ex_valid_o); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) begin
         issue(2'(i), 32'h300 + 32'(4 * i));
         step();
      end
      issue(2'd0, 32'h310);
      n_tests++; if (issue_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b want=0", issue_ready_o); end
      n_tests++; if (ex_stall_o !== 1'b1) begin n_fail++; $display("FAIL full_stall got=%b want=1", ex_stall_o); end
      n_tests++; if (unit_ready_o !== 4'b1111) begin n_fail++; $display("FAIL full_unit_ready got=%b want=1111", unit_ready_o); end
      unit_valid_i = 4'b0001;
      unit_r_i[0]  = 32'h30;
      step();
      unit_valid_i = '0;
      n_tests++; if (ex_valid_o !== 1'b1 || ex_pc_o !== 32'h300 || ex_r_o !== 32'h30) begin n_fail++; $display("FAIL full_head got v=%b pc=%h r=%h want 1/300/30", ex_valid_o, ex_pc_o, ex_r_o); end
      n_tests++; if (issue_ready_o !== 1'b0 || ex_stall_o !== 1'b1) begin n_fail++; $display("FAIL full_retire_no_free got rdy=%b stall=%b want 0/1", issue_ready_o, ex_stall_o); end
      step();
      n_tests++; if (issue_ready_o !== 1'b1 || ex_stall_o !== 1'b0) begin n_fail++; $display("FAIL full_refree got rdy=%b stall=%b want 1/0", issue_ready_o, ex_stall_o); end
      unit_valid_i = 4'b1111;
      for (int u = 0; u < 4; u++) unit_r_i[u] = 32'hA0 + 32'(u);
      n_tests++; if (unit_ready_o !== 4'b1110) begin n_fail++; $display("FAIL full_multi_ready got=%b want=1110", unit_ready_o); end
      step();
      issue_valid_i = 1'b0;
      unit_valid_i  = '0;
      for (int k = 1; k < 4; k++) begin
         n_tests++; if (ex_valid_o !== 1'b1 || ex_pc_o !== 32'h300 + 32'(4 * k) || ex_r_o !== 32'hA0 + 32'(k)) begin n_fail++; $display("FAIL full_drain%0d got v=%b pc=%h r=%h want 1/%h/%h", k, ex_valid_o, ex_pc_o, ex_r_o, 32'h300 + 32'(4 * k), 32'hA0 + 32'(k)); end
         step();
      end
      n_tests++; if (ex_valid_o !== 1'b0 || unit_ready_o !== 4'b0001) begin n_fail++; $display("FAIL full_same_cycle_drop got v=%b rdy=%b want 0/0001", ex_valid_o, unit_ready_o); end
      unit_valid_i = 4'b0001;
      unit_r_i[0]  = 32'hB0;
      step();
      unit_valid_i = '0;
      n_tests++; if (ex_valid_o !== 1'b1 || ex_pc_o !== 32'h310 || ex_r_o !== 32'hB0) begin n_fail++; $display("FAIL full_last got v=%b pc=%h r=%h want 1/310/b0", ex_valid_o, ex_pc_o, ex_r_o); end
      step();
      n_tests++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL full_empty got=%b want=0", ex_valid_o); end
   endtask

   task automatic test_stall();
      issue(2'd0, 32'h400);
      step();
      issue_valid_i = 1'b0;
      unit_valid_i  = 4'b0001;
      unit_r_i[0]   = 32'h44;
      mem_stall_i   = 1'b1;
      step();
      unit_valid_i = '0;
      for (int c = 0; c < 3; c++) begin
         n_tests++; if (ex_valid_o !== 1'b1 || ex_pc_o !== 32'h400 || ex_r_o !== 32'h44) begin n_fail++; $display("FAIL stall_hold%0d got v=%b pc=%h r=%h want 1/400/44", c, ex_valid_o, ex_pc_o, ex_r_o); end
         step();
      end
      mem_stall_i = 1'b0;
      issue(2'd1, 32'h404);
      step();
      n_tests++; if (ex_valid_o !== 1'b0 || unit_ready_o !== 4'b0010) begin n_fail++; $display("FAIL stall_swap got v=%b rdy=%b want 0/0010", ex_valid_o, unit_ready_o); end
      for (int i = 0; i < 3; i++) begin
         issue(2'((i + 2) % 4), 32'h408 + 32'(4 * i));
         n_tests++; if (issue_ready_o !== 1'b1) begin n_fail++; $display("FAIL stall_refill%0d got=%b want=1", i, issue_ready_o); end
         step();
      end
      issue_valid_i = 1'b0;
      n_tests++; if (issue_ready_o !== 1'b0) begin n_fail++; $display("FAIL stall_count_kept got=%b want=0", issue_ready_o); end
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      n_tests++; if (issue_ready_o !== 1'b1 || unit_ready_o !== 4'b0000) begin n_fail++; $display("FAIL stall_flush got rdy=%b urdy=%b want 1/0000", issue_ready_o, unit_ready_o); end
   endtask

   task automatic test_flush();
      issue(2'd0, 32'h500);
      step();
      issue(2'd1, 32'h504);
      step();
      issue(2'd2, 32'h508);
      step();
      issue_valid_i = 1'b0;
      unit_valid_i  = 4'b0001;
      unit_r_i[0]   = 32'h55;
      step();
      n_tests++; if (ex_valid_o !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid got=%b want=1", ex_valid_o); end
      flush_i       = 1'b1;
      issue(2'd3, 32'h50C);
      unit_valid_i  = 4'b0010;
      unit_r_i[1]   = 32'h77;
      step();
      flush_i       = 1'b0;
      issue_valid_i = 1'b0;
      n_tests++; if (ex_valid_o !== 1'b0 || unit_ready_o !== 4'b0000 || issue_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_clear got v=%b urdy=%b rdy=%b want 0/0000/1", ex_valid_o, unit_ready_o, issue_ready_o); end
      unit_valid_i = 4'b0100;
      unit_r_i[2]  = 32'h99;
      step();
      unit_valid_i = '0;
      n_tests++; if (ex_valid_o !== 1'b0 || unit_ready_o !== 4'b0000) begin n_fail++; $display("FAIL flush_drop got v=%b urdy=%b want 0/0000", ex_valid_o, unit_ready_o); end
      issue(2'd2, 32'h600);
      step();
      issue_valid_i = 1'b0;
      n_tests++; if (unit_ready_o !== 4'b0100 || ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_reissue got urdy=%b v=%b want 0100/0", unit_ready_o, ex_valid_o); end
      unit_valid_i = 4'b0100;
      unit_r_i[2]  = 32'h66;
      step();
      unit_valid_i = '0;
      n_tests++; if (ex_valid_o !== 1'b1 || ex_pc_o !== 32'h600 || ex_r_o !== 32'h66) begin n_fail++; $display("FAIL flush_after got v=%b pc=%h r=%h want 1/600/66", ex_valid_o, ex_pc_o, ex_r_o); end
      step();
   endtask

   task automatic test_wrap();
      int idx;
      int un;
      for (int g = 0; g < 3; g++) begin
         for (int k = 0; k < 3; k++) begin
            idx = g * 3 + k;
            issue(2'((g + k) % 4), 32'h700 + 32'(4 * idx));
            n_tests++; if (issue_ready_o !== 1'b1) begin n_fail++; $display("FAIL wrap_ready%0d got=%b want=1", idx, issue_ready_o); end
            step();
         end
         issue_valid_i = 1'b0;
         for (int k = 2; k >= 0; k--) begin
            idx           = g * 3 + k;
            un            = (g + k) % 4;
            unit_valid_i  = 4'b0001 << un;
            unit_r_i[un]  = 32'h1000 + 32'(idx);
            step();
         end
         unit_valid_i = '0;
         for (int k = 0; k < 3; k++) begin
            idx = g * 3 + k;
            n_tests++; if (ex_valid_o !== 1'b1 || ex_pc_o !== 32'h700 + 32'(4 * idx) || ex_r_o !== 32'h1000 + 32'(idx)) begin n_fail++; $display("FAIL wrap_retire%0d got v=%b pc=%h r=%h want 1/%h/%h", idx, ex_valid_o, ex_pc_o, ex_r_o, 32'h700 + 32'(4 * idx), 32'h1000 + 32'(idx)); end
            step();
         end
         n_tests++; if (ex_valid_o !== 1'b0 || unit_ready_o !== 4'b0000) begin n_fail++; $display("FAIL wrap_empty%0d got v=%b urdy=%b want 0/0000", g, ex_valid_o, unit_ready_o); end
      end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 4; i++) begin
         issue(2'(i), 32'h800 + 32'(4 * i));
         step();
      end
      issue_valid_i = 1'b0;
      n_tests++; if (issue_ready_o !== 1'b0) begin n_fail++; $display("FAIL midrst_full got=%b want=0", issue_ready_o); end
      #2;
      rst_ni = 1'b0;
      #1;
      n_tests++; if (issue_ready_o !== 1'b1 || unit_ready_o !== 4'b0000 || ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_async got rdy=%b urdy=%b v=%b want 1/0000/0", issue_ready_o, unit_ready_o, ex_valid_o); end
      step();
      @(negedge clk_i);
      rst_ni = 1'b1;
      step();
      n_tests++; if (issue_ready_o !== 1'b1 || unit_ready_o !== 4'b0000) begin n_fail++; $display("FAIL midrst_after got rdy=%b urdy=%b want 1/0000", issue_ready_o, unit_ready_o); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_reorder();
      test_full();
      test_stall();
      test_flush();
      test_wrap();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
